// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the
// MEM stage. Hits are answered combinationally; misses stall the pipeline
// while a word-serial writeback (if the victim is dirty) and refill run
// against main memory over a request/ready handshake.
module dcache_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cache_en,
  input  logic                  mem_write,
  input  logic                  is_byte,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_read_req,
  output logic                  mem_write_req,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  localparam int WB = $clog2(WORDS_PER_LINE);
  localparam int IB = $clog2(NUM_LINES);
  localparam int TB = ADDR_WIDTH - IB - WB - 2;
  localparam logic [WB-1:0] LAST_BEAT = WB'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  // Request address fields
  logic [1:0]    req_off;
  logic [WB-1:0] req_word;
  logic [IB-1:0] req_idx;
  logic [TB-1:0] req_tag;

  assign req_off  = addr[1:0];
  assign req_word = addr[WB+1:2];
  assign req_idx  = addr[IB+WB+1:WB+2];
  assign req_tag  = addr[ADDR_WIDTH-1:IB+WB+2];

  // Line state and storage
  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [NUM_LINES-1:0]  dirty_q, dirty_d;
  logic [TB-1:0]         tag_mem  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_mem [NUM_LINES*WORDS_PER_LINE];

  state_t        state_q, state_d;
  logic [WB-1:0] beat_q, beat_d;
  // The missing request is captured so memory addressing cannot move even
  // if upstream lets cache_en or addr change mid-miss.
  logic [IB-1:0] miss_idx_q, miss_idx_d;
  logic [TB-1:0] miss_tag_q, miss_tag_d;

  // Array write controls produced by the next-state logic
  logic                     data_we, tag_we;
  logic [IB+WB-1:0]         data_waddr;
  logic [DATA_WIDTH-1:0]    data_wval;

  logic                  hit;
  logic [DATA_WIDTH-1:0] hit_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [7:0]            byte_lanes [4];
  logic [7:0]            load_byte;

  assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign hit_word = data_mem[{req_idx, req_word}];

  // Little-endian byte lanes: lane gi is bits gi*8+7 : gi*8
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign byte_lanes[gi] = hit_word[gi*8 +: 8];
    assign merged_word[gi*8 +: 8] = (req_off == 2'(gi)) ? wdata[7:0] : hit_word[gi*8 +: 8];
  end

  assign load_byte = byte_lanes[req_off];

  // Next-state, handshake outputs and array write controls
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    miss_idx_d    = miss_idx_q;
    miss_tag_d    = miss_tag_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    data_we       = 1'b0;
    tag_we        = 1'b0;
    data_waddr    = {req_idx, req_word};
    data_wval     = wdata;
    rdata         = '0;
    stall         = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_read_req  = 1'b0;
    mem_write_req = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cache_en) begin
          if (hit) begin
            if (mem_write) begin
              data_we          = 1'b1;
              data_wval        = is_byte ? merged_word : wdata;
              dirty_d[req_idx] = 1'b1;
            end else begin
              rdata = is_byte ? {{(DATA_WIDTH-8){load_byte[7]}}, load_byte} : hit_word;
            end
          end else begin
            stall      = 1'b1;
            miss_idx_d = req_idx;
            miss_tag_d = req_tag;
            beat_d     = '0;
            state_d    = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : REFILL;
          end
        end
      end

      WRITEBACK: begin
        stall         = 1'b1;
        mem_write_req = 1'b1;
        mem_addr      = {tag_mem[miss_idx_q], miss_idx_q, beat_q, 2'b00};
        mem_wdata     = data_mem[{miss_idx_q, beat_q}];
        if (mem_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            dirty_d[miss_idx_q] = 1'b0;
            beat_d              = '0;
            state_d             = REFILL;
          end
        end
      end

      REFILL: begin
        stall        = 1'b1;
        mem_read_req = 1'b1;
        mem_addr     = {miss_tag_q, miss_idx_q, beat_q, 2'b00};
        if (mem_ready) begin
          data_we    = 1'b1;
          data_waddr = {miss_idx_q, beat_q};
          data_wval  = mem_rdata;
          beat_d     = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            valid_d[miss_idx_q] = 1'b1;
            tag_we              = 1'b1;
            beat_d              = '0;
            state_d             = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Control state; reset abandons any line operation in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      miss_idx_q <= miss_idx_d;
      miss_tag_q <= miss_tag_d;
    end
  end

  // Tag and data arrays; contents are meaningless until the line is valid
  always_ff @(posedge clk) begin
    if (!rst && data_we) data_mem[data_waddr] <= data_wval;
    if (!rst && tag_we)  tag_mem[miss_idx_q]  <= miss_tag_q;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a behavioural main memory that
// answers each beat after a programmable number of wait cycles.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst, cache_en, mem_write, is_byte;
  logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic        stall, mem_read_req, mem_write_req, mem_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk(clk), .rst(rst), .cache_en(cache_en), .mem_write(mem_write),
    .is_byte(is_byte), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Memory model: words written by the DUT override a fixed preload pattern
  logic [31:0] mem     [1024];
  logic        written [1024];
  int          mem_delay   = 1;
  logic        ready_force = 1'b0;
  logic [3:0]  wcnt = '0;
  logic [31:0] hold_addr, hold_wdata;
  logic        hold_we;
  int          stab_err = 0;
  int          both_err = 0;
  int          log_n    = 0;
  logic [31:0] log_addr [64];
  logic        log_we   [64];

  function automatic logic [31:0] preload(input logic [31:0] a);
    case (a[31:4])
      28'h004: return 32'hA0 + 32'(a[3:2]);
      28'h044: return 32'hB0 + 32'(a[3:2]);
      28'h084: return 32'hD0 + 32'(a[3:2]);
      default: return 32'h0;
    endcase
  endfunction

  wire mem_req = mem_read_req | mem_write_req;
  assign mem_ready = ready_force | (mem_req && (wcnt == mem_delay[3:0]));

  always_comb begin
    mem_rdata = preload(mem_addr);
    if (written[mem_addr[11:2]] === 1'b1) mem_rdata = mem[mem_addr[11:2]];
  end

  // Beat responder: counts wait cycles, logs completed beats, checks stability
  always @(posedge clk) begin
    if (mem_read_req && mem_write_req) both_err <= both_err + 1;
    if (!mem_req) begin
      wcnt <= '0;
    end else begin
      if (wcnt != 0 && (mem_addr != hold_addr || mem_wdata != hold_wdata ||
                        mem_write_req != hold_we))
        stab_err <= stab_err + 1;
      if (wcnt == 0) begin
        hold_addr  <= mem_addr;
        hold_wdata <= mem_wdata;
        hold_we    <= mem_write_req;
      end
      if (mem_ready) begin
        wcnt            <= '0;
        log_addr[log_n] <= mem_addr;
        log_we[log_n]   <= mem_write_req;
        log_n           <= log_n + 1;
        if (mem_write_req) begin
          mem[mem_addr[11:2]]     <= mem_wdata;
          written[mem_addr[11:2]] <= 1'b1;
        end
      end else begin
        wcnt <= wcnt + 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One cache access held until stall drops; returns data and stall cycles
  task automatic access(input logic we, input logic byt, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output int cyc);
    @(negedge clk);
    cache_en = 1'b1; mem_write = we; is_byte = byt; addr = a; wdata = wd;
    #1;
    cyc = 0;
    while (stall && cyc < 300) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("stall_released", {31'b0, stall}, 32'h0);
    rd = rdata;
    $display("access we=%0b byte=%0b addr=%h wdata=%h -> rdata=%h stall_cycles=%0d",
             we, byt, a, wd, rd, cyc);
    @(posedge clk); #1;
    cache_en = 1'b0; mem_write = 1'b0; is_byte = 1'b0;
  endtask

  task automatic chk_beats(input int start, input logic [31:0] base, input logic we);
    for (int i = 0; i < 4; i++) begin
      chk("beat_addr", log_addr[start+i], base + 32'(4*i));
      chk("beat_dir", {31'b0, log_we[start+i]}, {31'b0, we});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int cyc, s, k, st0;

    rst = 1'b1; cache_en = 1'b0; mem_write = 1'b0; is_byte = 1'b0;
    addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rreq", {31'b0, mem_read_req}, 32'h0);
    chk("rst_wreq", {31'b0, mem_write_req}, 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_mwdata", mem_wdata, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Clean miss: 1 miss cycle + 4 beats of 2 cycles
    s = log_n;
    access(1'b0, 1'b0, 32'h40, 32'h0, rd, cyc);
    chk("t1_rdata", rd, 32'hA0);
    chk("t1_cycles", cyc, 9);
    chk("t1_nbeats", log_n - s, 4);
    chk_beats(s, 32'h40, 1'b0);

    // Hit: same cycle, no memory traffic
    s = log_n;
    access(1'b0, 1'b0, 32'h44, 32'h0, rd, cyc);
    chk("t2_rdata", rd, 32'hA1);
    chk("t2_cycles", cyc, 0);
    chk("t2_nbeats", log_n - s, 0);

    // Word and byte stores / loads on a resident line
    access(1'b1, 1'b0, 32'h40, 32'h11223344, rd, cyc);
    chk("t3_sw_cycles", cyc, 0);
    access(1'b1, 1'b1, 32'h41, 32'h000000AB, rd, cyc);
    access(1'b0, 1'b0, 32'h40, 32'h0, rd, cyc);
    chk("t3_lw", rd, 32'h1122AB44);
    access(1'b0, 1'b1, 32'h41, 32'h0, rd, cyc);
    chk("t3_lb41", rd, 32'hFFFFFFAB);
    access(1'b0, 1'b1, 32'h40, 32'h0, rd, cyc);
    chk("t3_lb40", rd, 32'h00000044);
    access(1'b0, 1'b1, 32'h43, 32'h0, rd, cyc);
    chk("t3_lb43", rd, 32'h00000011);

    // Dirty conflict miss: writeback then refill
    s = log_n;
    access(1'b0, 1'b0, 32'h440, 32'h0, rd, cyc);
    chk("t4_rdata", rd, 32'hB0);
    chk("t4_cycles", cyc, 17);
    chk("t4_nbeats", log_n - s, 8);
    chk_beats(s, 32'h40, 1'b1);
    chk_beats(s + 4, 32'h440, 1'b0);
    chk("t4_wb_word0", mem[32'h40 >> 2], 32'h1122AB44);
    chk("t4_wb_word1", mem[32'h44 >> 2], 32'hA1);

    // Slow memory: 3 wait cycles per beat, dirty victim
    access(1'b1, 1'b0, 32'h444, 32'hC1, rd, cyc);
    mem_delay = 3;
    s = log_n;
    st0 = stab_err;
    access(1'b0, 1'b0, 32'h840, 32'h0, rd, cyc);
    chk("t5_rdata", rd, 32'hD0);
    chk("t5_cycles", cyc, 33);
    chk("t5_nbeats", log_n - s, 8);
    chk_beats(s, 32'h440, 1'b1);
    chk_beats(s + 4, 32'h840, 1'b0);
    chk("t5_wb_word1", mem[32'h444 >> 2], 32'hC1);
    chk("t5_stable", stab_err - st0, 0);
    mem_delay = 1;

    // Reset during refill beat 2
    s = log_n;
    @(negedge clk);
    cache_en = 1'b1; mem_write = 1'b0; is_byte = 1'b0; addr = 32'h40;
    k = 0;
    while ((log_n - s) < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t6_in_beat2", {31'b0, mem_read_req}, 32'h1);
    rst = 1'b1; cache_en = 1'b0;
    @(posedge clk); #1;
    chk("t6_rreq_off", {31'b0, mem_read_req}, 32'h0);
    chk("t6_wreq_off", {31'b0, mem_write_req}, 32'h0);
    chk("t6_stall_off", {31'b0, stall}, 32'h0);
    @(negedge clk); rst = 1'b0; ready_force = 1'b1;
    @(posedge clk); #1;
    chk("t6_idle_ready_ignored", {31'b0, mem_read_req | mem_write_req | stall}, 32'h0);
    @(negedge clk); ready_force = 1'b0;
    chk("t6_partial_beats", log_n - s, 2);
    s = log_n;
    access(1'b0, 1'b0, 32'h40, 32'h0, rd, cyc);
    chk("t6_rdata", rd, 32'h1122AB44);
    chk("t6_cycles", cyc, 9);
    chk("t6_nbeats", log_n - s, 4);
    chk_beats(s, 32'h40, 1'b0);

    chk("req_exclusive", both_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
